mem_loader: RTL
===============

# mem_loader

Streaming writer for the team's synchronous memories: accepts a byte stream over a valid/ready handshake and assembles it little-endian into WIDTH-bit words. It issues one single-cycle write per word into the write port of a RAM that shares its layout with `rom_sync`. This is how palettes and lookup tables are filled at run time, for example from the UART, instead of only via `$readmemh`. It sits between a byte source and a memory's write port, on the same clock as the memory's readers.

## Interface
- `WIDTH`, 8: memory word width in bits, 1..32.
- `DEPTH`, 256: memory depth in words.
- `ADDRW`, localparam `$clog2(DEPTH)`: address width.
- `BPW`, localparam `(WIDTH+7)/8`: bytes per word.

- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that begins a load. Only honoured in IDLE.
- `base` in ADDRW: first write address, sampled on `start`.
- `len` in ADDRW+1: number of words to write, sampled on `start`. Range 0..DEPTH.
- `s_data` in 8: incoming byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte this cycle.
- `we` out 1: write enable, one cycle per word.
- `waddr` out ADDRW: write address.
- `wdata` out WIDTH: write data.
- `busy` out 1: a load is in progress.
- `done` out 1: one-cycle pulse when a load completes.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: accepts bytes.
  - FIN: a single cycle that raises `done`.
- IDLE → LOAD on `start` when `len`≠0.
  - Latch `base` into the address counter.
  - Latch `len` into the word counter.
  - Clear the byte counter.
- IDLE → FIN on `start` when `len`=0. No writes are issued.
- In LOAD, `s_ready`=1. A byte is accepted in any cycle with `s_valid && s_ready`.
- Byte k of a word (k=0..BPW-1) fills bits [8k+7:8k] of the word. Bits at or above WIDTH are discarded.
- Accepting byte BPW-1 completes the word:
  - The registered `we`, `waddr` and `wdata` take the word's values.
  - The address counter increments modulo DEPTH, so the address wraps from DEPTH-1 to 0.
  - The word counter decrements.
  - The byte counter clears.
- If the completed word is the last one (word counter reaches 0), LOAD → FIN on the same edge.
- FIN → IDLE unconditionally.
- `busy` = (state ≠ IDLE).
- A `start` outside IDLE is ignored.
- Cycles with `s_valid` low insert gaps. The partial word is held across gaps with no timeout.
- A `rst_n` low edge at any time:
  - state → IDLE;
  - all counters cleared;
  - any partial word discarded;
  - no further `we`.

## Timing
- Reset values: `s_ready`=0, `we`=0, `waddr`=0, `wdata`=0, `busy`=0, `done`=0.
- `s_ready` is registered, derived from state only. It has no combinational path from `s_valid`.
- Write latency: if the final byte of a word is accepted in cycle N, `we`=1 in cycle N+1 with `waddr`/`wdata` stable. `we`=0 in all other cycles.
- Sustained throughput: one byte per cycle. Back-to-back words give `we` high every BPW cycles.
- Completion, `len`≥1:
  - The final byte is accepted in cycle N.
  - Cycle N+1 has `we`=1 and `done`=1 (state FIN), with `s_ready`=0.
  - Cycle N+2 is IDLE with `busy`=0.
- Completion, `len`=0: `start` in cycle N, then `done`=1 and `busy`=1 in cycle N+1, then IDLE in cycle N+2.
- `start` in cycle N gives `s_ready`=1 from cycle N+1.
- Bytes presented after completion are not accepted (`s_ready`=0).
- `waddr`/`wdata` hold their last values when `we`=0.

## Structure
- A shared `mem_pkg` holds the loader state enum `loader_state_t` {IDLE, LOAD, FIN}. Other memory-library blocks reuse it.
- One sub-module is natural: `byte_packer`. It takes the byte counter and shift register and emits the assembled word plus a word-complete strobe.
- Address wrap relies on an ADDRW-bit counter only when DEPTH is a power of two. Otherwise the counter uses an explicit compare against DEPTH-1.

## Test plan
- Word width 8, contiguous stream:
  - Setup: WIDTH=8, DEPTH=16, `start` with `base`=0, `len`=4, then bytes 0x11, 0x22, 0x33, 0x44 with `s_valid` held high.
  - Required: 4 consecutive `we` pulses to addresses 0..3 with data 0x11..0x44. `done` in the same cycle as the 4th `we`. `busy` low one cycle later.
- Multi-byte words, with gaps:
  - Setup: WIDTH=12 (BPW=2), `len`=2, bytes AB, CD, 12, 34 with `s_valid` gaps.
  - Required: `wdata`=0xDAB at `base`, then 0x412 at `base`+1. Each `we` arrives one cycle after the 2nd byte.
- Address wrap:
  - Setup: DEPTH=16, `base`=14, `len`=4.
  - Required: `waddr` sequence 14, 15, 0, 1.
- Zero length: `len`=0 gives no `we`, `done` one cycle after `start`, and `s_ready` never asserted.
- Reset mid-word:
  - Setup: WIDTH=16, `rst_n` low after 1 of 2 bytes, then a new load of 1 word with bytes 0x01, 0x02.
  - Required: single write 0x0201. The discarded byte never appears.
- Start while busy: a second `start` during LOAD, with different `base`/`len`, is ignored. The original sequence completes unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the memory library.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, FIN} loader_state_t;

    function automatic int bpw(input int width);
        return (width + 7) / 8;
    endfunction
endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: control, byte stream and RAM write port of the loader.
interface mem_loader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    localparam int ADDRW = $clog2(DEPTH);
    logic             start;
    logic [ADDRW-1:0] base;
    logic [ADDRW:0]   len;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic             we;
    logic [ADDRW-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;

    modport master (
        output start, base, len, s_data, s_valid,
        input  s_ready, we, waddr, wdata, busy, done
    );
    modport slave (
        input  start, base, len, s_data, s_valid,
        output s_ready, we, waddr, wdata, busy, done
    );
endinterface

// File: rtl/byte_packer.sv
// byte_packer: merges the incoming byte into the partial word at the current byte slot.
module byte_packer
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BCW = 1
) (
    input  logic [BCW-1:0]            cnt,
    input  logic [8*bpw(WIDTH)-1:0]   acc,
    input  logic [7:0]                data,
    input  logic                      take,
    output logic [8*bpw(WIDTH)-1:0]   next_acc,
    output logic [WIDTH-1:0]          word,
    output logic                      full
);
    localparam int BPW = bpw(WIDTH);

    assign next_acc = acc | ((8*BPW)'(data) << {cnt, 3'b000});
    assign word = next_acc[WIDTH-1:0];
    assign full = take && cnt == BCW'(BPW - 1);
endmodule

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream little-endian into WIDTH-bit words and
// issues one registered RAM write per completed word.
module mem_loader
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_loader_if.slave bus
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int BPW = bpw(WIDTH);
    localparam int BCW = BPW > 1 ? $clog2(BPW) : 1;
    localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);
    localparam bit POW2 = (1 << ADDRW) == DEPTH;

    loader_state_t    state;
    logic [ADDRW-1:0] addr, next_addr;
    logic [ADDRW:0]   words;
    logic [BCW-1:0]   cnt;
    logic [8*BPW-1:0] acc, next_acc;
    logic [WIDTH-1:0] word;
    logic             full, take;

    assign take = bus.s_valid && bus.s_ready;
    // a power-of-two depth wraps for free in the ADDRW-bit counter
    assign next_addr = (POW2 || addr != LAST) ? addr + 1'b1 : '0;

    byte_packer #(.WIDTH(WIDTH), .BCW(BCW)) u_packer (
        .cnt      (cnt),
        .acc      (acc),
        .data     (bus.s_data),
        .take     (take),
        .next_acc (next_acc),
        .word     (word),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr        <= '0;
            words       <= '0;
            cnt         <= '0;
            acc         <= '0;
            bus.s_ready <= 1'b0;
            bus.we      <= 1'b0;
            bus.waddr   <= '0;
            bus.wdata   <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.we   <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    addr        <= bus.base;
                    words       <= bus.len;
                    cnt         <= '0;
                    acc         <= '0;
                    state       <= bus.len == '0 ? FIN : LOAD;
                    bus.s_ready <= bus.len != '0;
                    bus.done    <= bus.len == '0;
                    bus.busy    <= 1'b1;
                end
                LOAD: if (full) begin
                    bus.we    <= 1'b1;
                    bus.waddr <= addr;
                    bus.wdata <= word;
                    addr      <= next_addr;
                    words     <= words - 1'b1;
                    cnt       <= '0;
                    acc       <= '0;
                    if (words == (ADDRW+1)'(1)) begin
                        state       <= FIN;
                        bus.s_ready <= 1'b0;
                        bus.done    <= 1'b1;
                    end
                end else if (take) begin
                    cnt <= cnt + 1'b1;
                    acc <= next_acc;
                end
                FIN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
